// File: rtl/axi4lite_master_arbiter_if.sv
// AXI4-Lite master-side bus bundle shared between the arbiter and the slave register file.
// The master modport drives requests and ready-for-response signals; the slave modport is its mirror.
interface axi4lite_master_arbiter_if #(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 4
);
    logic [C_M_AXI_ADDR_WIDTH-1:0] m_awaddr;
    logic [2:0]                    m_awprot;
    logic                          m_awvalid;
    logic                          m_awready;
    logic [C_M_AXI_DATA_WIDTH-1:0] m_wdata;
    logic                          m_wvalid;
    logic                          m_wready;
    logic [1:0]                    m_bresp;
    logic                          m_bvalid;
    logic                          m_bready;
    logic [C_M_AXI_ADDR_WIDTH-1:0] m_araddr;
    logic [2:0]                    m_arprot;
    logic                          m_arvalid;
    logic                          m_arready;
    logic [C_M_AXI_DATA_WIDTH-1:0] m_rdata;
    logic [1:0]                    m_rresp;
    logic                          m_rvalid;
    logic                          m_rready;

    modport master (
        output m_awaddr, m_awprot, m_awvalid, m_wdata, m_wvalid, m_bready,
               m_araddr, m_arprot, m_arvalid, m_rready,
        input  m_awready, m_wready, m_bresp, m_bvalid, m_arready,
               m_rdata, m_rresp, m_rvalid
    );

    modport slave (
        input  m_awaddr, m_awprot, m_awvalid, m_wdata, m_wvalid, m_bready,
               m_araddr, m_arprot, m_arvalid, m_rready,
        output m_awready, m_wready, m_bresp, m_bvalid, m_arready,
               m_rdata, m_rresp, m_rvalid
    );
endinterface

// File: rtl/axi4lite_master_arbiter.sv
// Two-requester round-robin front end for a single AXI4-Lite master port.
// One single-beat read or write per grant; response is routed back to the granted requester.
module axi4lite_master_arbiter #(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 4
) (
    input  logic                            m_aclk,
    input  logic                            m_areset,
    input  logic [1:0]                      req_valid,
    input  logic [1:0]                      req_write,
    input  logic [2*C_M_AXI_ADDR_WIDTH-1:0] req_addr,
    input  logic [2*C_M_AXI_DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]                      req_ready,
    output logic [1:0]                      done,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_data,
    output logic [1:0]                      rsp_resp,
    axi4lite_master_arbiter_if.master       m_axi
);
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int AW = C_M_AXI_ADDR_WIDTH;

    typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;

    state_t                state, state_n;
    logic                  last_grant;
    logic                  gnt;
    logic                  g_q;
    logic [AW-1:0]         addr_q;
    logic [DW-1:0]         wdata_q;
    logic                  aw_done, w_done;
    logic                  aw_hs, w_hs, take;
    logic [1:0][AW-1:0]    addr_lanes;
    logic [1:0][DW-1:0]    wdata_lanes;

    assign addr_lanes  = req_addr;
    assign wdata_lanes = req_wdata;

    // Contention goes to whoever did not win last; a lone requester always wins.
    assign gnt  = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
    assign take = (state == IDLE) && (|req_valid);

    assign aw_hs = (state == WR) && !aw_done && m_axi.m_awready;
    assign w_hs  = (state == WR) && !w_done  && m_axi.m_wready;

    always_ff @(posedge m_aclk) begin
        if (m_areset) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (|req_valid) state_n = req_write[gnt] ? WR : RD_ADDR;
            WR:      if ((aw_done || aw_hs) && (w_done || w_hs)) state_n = WR_RESP;
            WR_RESP: if (m_axi.m_bvalid) state_n = DONE;
            RD_ADDR: if (m_axi.m_arready) state_n = RD_DATA;
            RD_DATA: if (m_axi.m_rvalid) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Event pulses are masked during reset so an aborted transaction never reports.
    always_comb begin
        req_ready       = '0;
        done            = '0;
        m_axi.m_awvalid = 1'b0;
        m_axi.m_wvalid  = 1'b0;
        m_axi.m_bready  = 1'b0;
        m_axi.m_arvalid = 1'b0;
        m_axi.m_rready  = 1'b0;
        case (state)
            IDLE:    if (!m_areset && (|req_valid)) req_ready[gnt] = 1'b1;
            WR: begin
                m_axi.m_awvalid = !aw_done;
                m_axi.m_wvalid  = !w_done;
            end
            WR_RESP: m_axi.m_bready  = 1'b1;
            RD_ADDR: m_axi.m_arvalid = 1'b1;
            RD_DATA: m_axi.m_rready  = 1'b1;
            DONE:    if (!m_areset) done[g_q] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge m_aclk) begin
        if (m_areset) begin
            last_grant <= 1'b1;
            g_q        <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            rsp_data   <= '0;
            rsp_resp   <= '0;
        end else begin
            if (take) begin
                g_q     <= gnt;
                addr_q  <= addr_lanes[gnt];
                wdata_q <= wdata_lanes[gnt];
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
            if (state == WR_RESP && m_axi.m_bvalid) rsp_resp <= m_axi.m_bresp;
            if (state == RD_DATA && m_axi.m_rvalid) begin
                rsp_data <= m_axi.m_rdata;
                rsp_resp <= m_axi.m_rresp;
            end
            if (state == DONE) last_grant <= g_q;
        end
    end

    assign m_axi.m_awaddr = addr_q;
    assign m_axi.m_araddr = addr_q;
    assign m_axi.m_wdata  = wdata_q;
    assign m_axi.m_awprot = 3'b000;
    assign m_axi.m_arprot = 3'b000;
endmodule

// File: tb/tb_axi4lite_master_arbiter.sv
// Directed and randomized bench for the two-requester AXI4-Lite arbiter.
// A delay-programmable slave model answers the bus; expectations come from round-robin rules.
module tb_axi4lite_master_arbiter;
    localparam int DW = 32;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]         req_valid = '0;
    logic [1:0]         req_write = '0;
    logic [1:0][AW-1:0] req_addr  = '0;
    logic [1:0][DW-1:0] req_wdata = '0;
    logic [1:0]         req_ready, done;
    logic [DW-1:0]      rsp_data;
    logic [1:0]         rsp_resp;

    axi4lite_master_arbiter_if #(.C_M_AXI_DATA_WIDTH(DW), .C_M_AXI_ADDR_WIDTH(AW)) bus ();

    axi4lite_master_arbiter #(.C_M_AXI_DATA_WIDTH(DW), .C_M_AXI_ADDR_WIDTH(AW)) dut (
        .m_aclk(clk), .m_areset(rst),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .done(done), .rsp_data(rsp_data), .rsp_resp(rsp_resp),
        .m_axi(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] outs();
        return 128'({req_ready, done, rsp_data, rsp_resp, bus.m_awaddr, bus.m_awprot, bus.m_awvalid,
                     bus.m_wdata, bus.m_wvalid, bus.m_bready, bus.m_araddr, bus.m_arprot,
                     bus.m_arvalid, bus.m_rready});
    endfunction

    // Slave model: each ready rises after its valid has waited *_dly cycles;
    // a response rises *_dly cycles after its request handshakes complete.
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]    bresp_v = '0, rresp_v = '0;
    logic [DW-1:0] rdata_v = '0;
    int   aw_wait, w_wait, ar_wait, b_wait, r_wait;
    logic got_aw, got_w, got_ar;
    logic aw_hs, w_hs, ar_hs;

    assign bus.m_awready = bus.m_awvalid && (aw_wait >= aw_dly);
    assign bus.m_wready  = bus.m_wvalid  && (w_wait  >= w_dly);
    assign bus.m_arready = bus.m_arvalid && (ar_wait >= ar_dly);
    assign bus.m_bresp   = bresp_v;
    assign bus.m_rresp   = rresp_v;
    assign bus.m_rdata   = rdata_v;
    assign aw_hs = bus.m_awvalid && bus.m_awready;
    assign w_hs  = bus.m_wvalid  && bus.m_wready;
    assign ar_hs = bus.m_arvalid && bus.m_arready;

    always @(posedge clk) begin
        if (rst) begin
            aw_wait <= 0; w_wait <= 0; ar_wait <= 0; b_wait <= 0; r_wait <= 0;
            got_aw <= 1'b0; got_w <= 1'b0; got_ar <= 1'b0;
            bus.m_bvalid <= 1'b0; bus.m_rvalid <= 1'b0;
        end else begin
            aw_wait <= (bus.m_awvalid && !bus.m_awready) ? aw_wait + 1 : 0;
            w_wait  <= (bus.m_wvalid  && !bus.m_wready)  ? w_wait + 1  : 0;
            ar_wait <= (bus.m_arvalid && !bus.m_arready) ? ar_wait + 1 : 0;
            if (bus.m_bvalid && bus.m_bready) begin
                bus.m_bvalid <= 1'b0; got_aw <= 1'b0; got_w <= 1'b0; b_wait <= 0;
            end else begin
                if (aw_hs) got_aw <= 1'b1;
                if (w_hs)  got_w  <= 1'b1;
                if ((got_aw || aw_hs) && (got_w || w_hs) && !bus.m_bvalid) begin
                    if (b_wait >= b_dly) bus.m_bvalid <= 1'b1;
                    else                 b_wait <= b_wait + 1;
                end
            end
            if (bus.m_rvalid && bus.m_rready) begin
                bus.m_rvalid <= 1'b0; got_ar <= 1'b0; r_wait <= 0;
            end else begin
                if (ar_hs) got_ar <= 1'b1;
                if ((got_ar || ar_hs) && !bus.m_rvalid) begin
                    if (r_wait >= r_dly) bus.m_rvalid <= 1'b1;
                    else                 r_wait <= r_wait + 1;
                end
            end
        end
    end

    // Bus monitor, sampled mid-cycle.
    int aw_beats = 0, w_beats = 0, ar_beats = 0, rdy_pulses = 0, done_cyc = 0;
    logic [AW-1:0] aw_seen, ar_seen;
    logic [DW-1:0] w_seen;
    always @(negedge clk) begin
        if (aw_hs) begin aw_beats++; aw_seen = bus.m_awaddr; end
        if (w_hs)  begin w_beats++;  w_seen  = bus.m_wdata;  end
        if (ar_hs) begin ar_beats++; ar_seen = bus.m_araddr; end
        if (req_ready != 2'b00) rdy_pulses++;
        if (done != 2'b00) done_cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic wait_rdy(output logic [1:0] r);
        r = 2'b00;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin r = req_ready; return; end
        end
    endtask

    task automatic wait_done(output logic [1:0] d);
        d = 2'b00;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done != 2'b00) begin d = done; return; end
        end
    endtask

    task automatic do_txn(input int id, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, output logic [1:0] gr, output logic [1:0] dn);
        @(posedge clk); #1;
        req_valid[id] = 1'b1; req_write[id] = wr; req_addr[id] = a; req_wdata[id] = wd;
        wait_rdy(gr);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        wait_done(dn);
    endtask

    logic [1:0]         gr, dn;
    logic [1:0]         rv, rw;
    logic [1:0][AW-1:0] ra;
    logic [1:0][DW-1:0] rd;
    logic               model_last, g;
    logic [DW-1:0]      exp_data;
    logic [1:0]         exp_resp;
    int                 aw0, w0, ar0, rdy0, dc0, exp_done;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk); chk("reset_outs", outs(), 128'(0));
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk); chk("idle_outs", outs(), 128'(0));

        // T1: zero-wait write from requester 0
        @(posedge clk); #1;
        req_valid = 2'b01; req_write = 2'b01; req_addr[0] = 4'h4; req_wdata[0] = 32'hDEADBEEF;
        @(negedge clk); chk("t1_ready", 128'(req_ready), 128'(2'b01));
        @(posedge clk); #1; req_valid = 2'b00;
        @(negedge clk);
        chk("t1_aw_w_valid", 128'({bus.m_awvalid, bus.m_wvalid}), 128'(2'b11));
        chk("t1_awaddr", 128'(bus.m_awaddr), 128'(4'h4));
        chk("t1_wdata", 128'(bus.m_wdata), 128'(32'hDEADBEEF));
        @(negedge clk); chk("t1_resp_phase", 128'({bus.m_awvalid, bus.m_wvalid, bus.m_bready}), 128'(3'b001));
        @(negedge clk); chk("t1_done", 128'(done), 128'(2'b01)); chk("t1_bresp", 128'(rsp_resp), 128'(0));
        @(negedge clk); chk("t1_done_pulse", 128'(done), 128'(0));

        // T2: read from requester 1 with slow AR and R
        @(posedge clk); #1;
        ar_dly = 2; r_dly = 3; rdata_v = 32'h12345678; rresp_v = 2'b00;
        req_valid = 2'b10; req_write = 2'b00; req_addr[1] = 4'h8;
        @(negedge clk); chk("t2_ready", 128'(req_ready), 128'(2'b10));
        @(posedge clk); #1; req_valid = 2'b00;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); chk("t2_arvalid_held", 128'({bus.m_arvalid, bus.m_araddr}), 128'({1'b1, 4'h8}));
        end
        @(negedge clk); chk("t2_ar_drop", 128'({bus.m_arvalid, bus.m_rready}), 128'(2'b01));
        wait_done(dn);
        chk("t2_done", 128'(dn), 128'(2'b10));
        chk("t2_rdata", 128'(rsp_data), 128'(32'h12345678));

        // T3: both requesters held valid for four transactions
        @(posedge clk); #1;
        ar_dly = 0; r_dly = 0;
        req_valid = 2'b11; req_write = 2'b00; req_addr[0] = 4'h1; req_addr[1] = 4'h2;
        for (int k = 0; k < 4; k++) begin
            wait_rdy(gr);
            chk("t3_grant_order", 128'(gr), 128'((k % 2) ? 2'b10 : 2'b01));
            wait_done(dn);
            chk("t3_done_order", 128'(dn), 128'((k % 2) ? 2'b10 : 2'b01));
        end
        @(posedge clk); #1; req_valid = 2'b00;

        // T4: AW accepted two cycles before W
        aw_dly = 0; w_dly = 2; b_dly = 0; bresp_v = 2'b00;
        aw0 = aw_beats; w0 = w_beats;
        req_valid = 2'b01; req_write = 2'b01; req_addr[0] = 4'hC; req_wdata[0] = 32'hA5A5_5A5A;
        @(negedge clk); chk("t4_ready", 128'(req_ready), 128'(2'b01));
        @(posedge clk); #1; req_valid = 2'b00;
        @(negedge clk); chk("t4_both_valid", 128'({bus.m_awvalid, bus.m_wvalid}), 128'(2'b11));
        @(negedge clk); chk("t4_aw_dropped", 128'({bus.m_awvalid, bus.m_wvalid}), 128'(2'b01));
        @(negedge clk); chk("t4_w_handshake", 128'({bus.m_awvalid, bus.m_wvalid, bus.m_wready}), 128'(3'b011));
        wait_done(dn);
        chk("t4_done", 128'(dn), 128'(2'b01));
        chk("t4_beats", 128'({aw_beats - aw0, w_beats - w0}), 128'({32'd1, 32'd1}));
        chk("t4_wdata_seen", 128'(w_seen), 128'(32'hA5A5_5A5A));
        w_dly = 0;

        // T5: error responses pass through
        rresp_v = 2'b10; rdata_v = 32'h0BADF00D;
        do_txn(0, 1'b0, 4'h3, 32'h0, gr, dn);
        chk("t5_rd_done", 128'({gr, dn}), 128'(4'b0101));
        chk("t5_rresp", 128'({rsp_resp, rsp_data}), 128'({2'b10, 32'h0BADF00D}));
        bresp_v = 2'b11;
        do_txn(1, 1'b1, 4'h5, 32'h1111_2222, gr, dn);
        chk("t5_wr_done", 128'({gr, dn}), 128'(4'b1010));
        chk("t5_bresp_keeps_rdata", 128'({rsp_resp, rsp_data}), 128'({2'b11, 32'h0BADF00D}));

        // T6: reset during RD_DATA
        @(posedge clk); #1;
        r_dly = 6; req_valid = 2'b10; req_write = 2'b00; req_addr[1] = 4'h2;
        wait_rdy(gr);
        @(posedge clk); #1; req_valid = 2'b00;
        for (int i = 0; i < 10 && !bus.m_rready; i++) @(negedge clk);
        chk("t6_in_rd_data", 128'(bus.m_rready), 128'(1));
        @(posedge clk); #1; rst = 1'b1; dc0 = done_cyc;
        @(posedge clk); #1;
        @(negedge clk); chk("t6_reset_outs", outs(), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0; r_dly = 0; req_valid = 2'b11; req_write = 2'b00;
        @(negedge clk); chk("t6_regrant_req0", 128'(req_ready), 128'(2'b01));
        chk("t6_no_done", 128'(done_cyc), 128'(dc0));
        @(posedge clk); #1; req_valid = 2'b00;
        wait_done(dn); chk("t6_done", 128'(dn), 128'(2'b01));

        // Randomized traffic against a round-robin reference
        @(posedge clk); #1; rst = 1'b1;
        repeat (2) @(posedge clk); #1; rst = 1'b0;
        model_last = 1'b1; exp_data = '0; exp_resp = 2'b00; rv = 2'b00; rw = 2'b00;
        ra = '0; rd = '0; exp_done = done_cyc;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            chk("rnd_done_count", 128'(done_cyc), 128'(exp_done));
            for (int i = 0; i < 2; i++) begin
                if (!rv[i] && $urandom_range(3) != 0) begin
                    rv[i] = 1'b1; rw[i] = 1'($urandom); ra[i] = AW'($urandom); rd[i] = $urandom;
                end
            end
            if (rv == 2'b00) begin
                rv[0] = 1'b1; rw[0] = 1'($urandom); ra[0] = AW'($urandom); rd[0] = $urandom;
            end
            aw_dly = $urandom_range(3); w_dly = $urandom_range(3); b_dly = $urandom_range(3);
            ar_dly = $urandom_range(3); r_dly = $urandom_range(3);
            bresp_v = 2'($urandom); rresp_v = 2'($urandom); rdata_v = $urandom;
            req_valid = rv; req_write = rw; req_addr = ra; req_wdata = rd;
            if (rv == 2'b11) g = !model_last;
            else             g = rv[1];
            aw0 = aw_beats; w0 = w_beats; ar0 = ar_beats; rdy0 = rdy_pulses;
            wait_rdy(gr);
            chk("rnd_grant", 128'(gr), 128'(g ? 2'b10 : 2'b01));
            @(posedge clk); #1;
            rv[g] = 1'b0; req_valid = rv;
            req_addr[g] = AW'($urandom); req_wdata[g] = $urandom; req_write[g] = 1'($urandom);
            wait_done(dn);
            chk("rnd_done", 128'(dn), 128'(g ? 2'b10 : 2'b01));
            if (rw[g]) begin
                exp_resp = bresp_v;
                chk("rnd_wr_beats", 128'({aw_beats - aw0, w_beats - w0, ar_beats - ar0}),
                    128'({32'd1, 32'd1, 32'd0}));
                chk("rnd_wr_payload", 128'({aw_seen, w_seen}), 128'({ra[g], rd[g]}));
            end else begin
                exp_resp = rresp_v; exp_data = rdata_v;
                chk("rnd_rd_beats", 128'({aw_beats - aw0, w_beats - w0, ar_beats - ar0}),
                    128'({32'd0, 32'd0, 32'd1}));
                chk("rnd_rd_addr", 128'(ar_seen), 128'(ra[g]));
            end
            chk("rnd_rsp", 128'({rsp_resp, rsp_data}), 128'({exp_resp, exp_data}));
            chk("rnd_one_accept", 128'(rdy_pulses - rdy0), 128'(1));
            model_last = g;
            exp_done++;
        end
        @(posedge clk); #1;
        chk("rnd_final_done_count", 128'(done_cyc), 128'(exp_done));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
